ram_dump_tx: RTL and testbench

RAM_DUMP_TX -- requirements
Module: ram_dump_tx

---
 rtl/ram_dump_tx.sv | 156 +++++++++++++++
 tb/tb_ram_dump_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_dump_tx.sv
// rtl/ram_dump_tx.sv - 8N1 serial dump of data-memory words, MSB byte first, LSB bit first
// Optional trailing XOR checksum frame enabled by defining RAM_DUMP_CHECKSUM_EN
module ram_dump_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORDS        = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [5:0]  ram_addr_display,
    input  logic [31:0] ram_display,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;

    localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [5:0]     WORD_LAST = 6'(WORDS - 1);

    logic [2:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [5:0]    word_cnt;
    logic [31:0]   word_reg;
    logic [7:0]    cur_byte;
    logic [7:0]    tx_byte;
    logic          baud_tick;
    logic          in_csum;

    assign baud_tick        = (baud_cnt == BAUD_LAST);
    assign cur_byte         = word_reg[{byte_idx, 3'b000} +: 8];
    assign ram_addr_display = word_cnt;
    assign busy             = (state != S_IDLE);

`ifdef RAM_DUMP_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
    logic [7:0] csum;
    logic       csum_phase;
    assign in_csum = csum_phase;
    assign tx_byte = csum_phase ? csum : cur_byte;
`else
    localparam bit CSUM_EN = 1'b0;
    assign in_csum = 1'b0;
    assign tx_byte = cur_byte;
`endif

    // The finishing NEXT_BYTE cycle is the last word's last byte, or the checksum frame when enabled
    assign done = (state == S_NEXT) && (byte_idx == 2'd0) && (word_cnt == WORD_LAST)
                  && (in_csum == CSUM_EN);

    always_comb begin
        tx = 1'b1;
        case (state)
            S_START: tx = 1'b0;
            S_DATA:  tx = tx_byte[bit_idx];
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 2'd0;
            word_cnt <= 6'd0;
            word_reg <= 32'd0;
`ifdef RAM_DUMP_CHECKSUM_EN
            csum       <= 8'd0;
            csum_phase <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    if (start) begin
                        word_cnt <= 6'd0;
                        state    <= S_FETCH;
`ifdef RAM_DUMP_CHECKSUM_EN
                        csum       <= 8'd0;
                        csum_phase <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    word_reg <= ram_display;
                    byte_idx <= 2'd3;
                    baud_cnt <= '0;
                    state    <= S_START;
                end
                S_START: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        state    <= S_NEXT;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    baud_cnt <= '0;
`ifdef RAM_DUMP_CHECKSUM_EN
                    if (!csum_phase) begin
                        csum <= csum ^ cur_byte;
                    end
`endif
                    if (!in_csum && byte_idx != 2'd0) begin
                        byte_idx <= byte_idx - 2'd1;
                        state    <= S_START;
                    end else if (!in_csum && word_cnt != WORD_LAST) begin
                        word_cnt <= word_cnt + 6'd1;
                        state    <= S_FETCH;
`ifdef RAM_DUMP_CHECKSUM_EN
                    end else if (!in_csum) begin
                        csum_phase <= 1'b1;
                        state      <= S_START;
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dump_tx.sv
// tb/tb_ram_dump_tx.sv - self-checking bench for ram_dump_tx against a cycle-timing reference model
module tb_ram_dump_tx;

    localparam int CPB = 4;
    localparam int FR  = 10 * CPB;
    localparam int FC  = FR + 1;
    localparam int WC  = 2 + 4 * FC - 1;
`ifdef RAM_DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start64;
    logic [5:0]  addr1, addr64;
    logic [31:0] rd1, rd64, mem1;
    logic [31:0] mem64 [0:63];
    logic        tx1, busy1, done1, tx64, busy64, done64;

    int checks = 0;
    int errors = 0;
    logic [7:0] eb  [0:256];
    logic [7:0] cap [0:256];

    typedef struct {
        logic [31:0] word;
        bit          rw;
        logic [31:0] rw_val;
        logic [31:0] exp_bytes;
        logic [7:0]  exp_cs;
    } vec_t;
    vec_t vt [5];

    always #5 clk = ~clk;

    assign rd1  = mem1;
    assign rd64 = mem64[addr64];

    ram_dump_tx #(.CLKS_PER_BIT(CPB), .WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .ram_addr_display(addr1),
        .ram_display(rd1), .tx(tx1), .busy(busy1), .done(done1)
    );

    ram_dump_tx #(.CLKS_PER_BIT(CPB), .WORDS(64)) dut64 (
        .clk(clk), .rst(rst), .start(start64), .ram_addr_display(addr64),
        .ram_display(rd64), .tx(tx64), .busy(busy64), .done(done64)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int frame_start(input int k, input int w);
        if (k < 4 * w) return (k / 4) * WC + 1 + (k % 4) * FC;
        return w * WC;
    endfunction

    // Starts a dump and checks tx/busy/done/address every cycle until the DUT is idle again
    task automatic check_dump(input bit big, input int w, input bit rw,
                              input logic [31:0] rw_val, input bit hold);
        int nfr, total, s, r, bi, ea;
        logic et, at, ab, ad;
        logic [5:0] aa;
        logic [31:0] wd;
        logic [7:0] cs;
        cs = 8'd0;
        for (int i = 0; i < w; i++) begin
            wd = big ? mem64[i] : mem1;
            for (int b = 0; b < 4; b++) begin
                eb[4*i+b] = wd[31-8*b -: 8];
                cs = cs ^ eb[4*i+b];
            end
        end
        eb[4*w] = cs;
        nfr   = 4 * w + CS;
        total = w * WC + CS * FC;
        @(negedge clk);
        if (big) start64 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin
            start1  = 1'b0;
            start64 = 1'b0;
        end
        for (int t = 0; t <= total; t++) begin
            at = big ? tx64   : tx1;
            ab = big ? busy64 : busy1;
            ad = big ? done64 : done1;
            aa = big ? addr64 : addr1;
            et = 1'b1;
            for (int k = 0; k < nfr; k++) begin
                s = frame_start(k, w);
                if (t >= s && t < s + FR) begin
                    r  = t - s;
                    bi = r / CPB;
                    if (bi == 0) et = 1'b0;
                    else if (bi <= 8) begin
                        et = eb[k][bi-1];
                        if (r % CPB == CPB / 2) cap[k][bi-1] = at;
                    end
                end
            end
            ea = (t < total) ? t / WC : w - 1;
            if (ea > w - 1) ea = w - 1;
            chk($sformatf("tx@%0d", t), {31'd0, at}, {31'd0, et});
            chk($sformatf("busy@%0d", t), {31'd0, ab}, (t < total) ? 32'd1 : 32'd0);
            chk($sformatf("done@%0d", t), {31'd0, ad}, (t == total - 1) ? 32'd1 : 32'd0);
            chk($sformatf("addr@%0d", t), {26'd0, aa}, ea);
            if (rw && t == 1) begin
                if (big) mem64[0] = rw_val; else mem1 = rw_val;
            end
            if (t < total) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dn, t;
        vt[0] = '{32'h12345678, 1'b0, 32'h0,        32'h12345678, 8'h08};
        vt[1] = '{32'hA5000FF0, 1'b1, 32'h00000000, 32'hA5000FF0, 8'h5A};
        vt[2] = '{32'hFFFFFFFF, 1'b0, 32'h0,        32'hFFFFFFFF, 8'h00};
        vt[3] = '{32'h00000001, 1'b1, 32'hDEADBEEF, 32'h00000001, 8'h01};
        vt[4] = '{32'h80C33C01, 1'b0, 32'h0,        32'h80C33C01, 8'h7E};

        rst = 1'b0; start1 = 1'b0; start64 = 1'b0; mem1 = 32'd0;
        for (int i = 0; i < 64; i++) mem64[i] = 32'(i);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx1", {31'd0, tx1}, 32'd1);
        chk("reset_busy1", {31'd0, busy1}, 32'd0);
        chk("reset_done1", {31'd0, done1}, 32'd0);
        chk("reset_tx64", {31'd0, tx64}, 32'd1);
        chk("reset_busy64", {31'd0, busy64}, 32'd0);
        chk("reset_addr64", {26'd0, addr64}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            mem1 = vt[i].word;
            check_dump(1'b0, 1, vt[i].rw, vt[i].rw_val, 1'b0);
            for (int b = 0; b < 4; b++)
                chk($sformatf("vec%0d_byte%0d", i, b), {24'd0, cap[b]},
                    {24'd0, vt[i].exp_bytes[31-8*b -: 8]});
`ifdef RAM_DUMP_CHECKSUM_EN
            chk($sformatf("vec%0d_csum", i), {24'd0, cap[4]}, {24'd0, vt[i].exp_cs});
`endif
        end

        check_dump(1'b1, 64, 1'b0, 32'd0, 1'b0);
        chk("seq64_final_addr", {26'd0, addr64}, 32'd63);
        for (int b = 0; b < 256; b++)
            if (b % 4 == 3) chk($sformatf("seq64_byte%0d", b), {24'd0, cap[b]}, b / 4);

        // start held across a whole dump: exactly one re-arm, and only from IDLE
        mem1 = 32'hCAFEF00D;
        check_dump(1'b0, 1, 1'b0, 32'd0, 1'b1);
        @(posedge clk); #1;
        chk("rearm_busy", {31'd0, busy1}, 32'd1);
        start1 = 1'b0;
        n = 0; dn = 0;
        while (busy1 && n < 1000) begin
            dn += int'(done1);
            @(posedge clk); #1;
            n++;
        end
        chk("rearm_done_count", dn, 32'd1);
        chk("rearm_busy_cycles", n, 32'(WC + CS * FC));

        // reset during DATA bit 3 of byte index 2 of word 1
        for (int i = 0; i < 64; i++) mem64[i] = $urandom;
        @(negedge clk);
        start64 = 1'b1;
        @(posedge clk); #1;
        start64 = 1'b0;
        t = 0;
        while (t < 224) begin
            @(posedge clk); #1;
            t++;
        end
        chk("pre_reset_addr", {26'd0, addr64}, 32'd1);
        chk("pre_reset_tx", {31'd0, tx64}, {31'd0, mem64[1][19]});
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_tx", {31'd0, tx64}, 32'd1);
        chk("abort_busy", {31'd0, busy64}, 32'd0);
        chk("abort_addr", {26'd0, addr64}, 32'd0);
        chk("abort_done", {31'd0, done64}, 32'd0);
        start1 = 1'b1; start64 = 1'b1;
        @(posedge clk); #1;
        chk("start_in_reset_busy1", {31'd0, busy1}, 32'd0);
        chk("start_in_reset_busy64", {31'd0, busy64}, 32'd0);
        rst = 1'b1; start1 = 1'b0; start64 = 1'b0;
        dn = 0;
        for (int i = 0; i < 300; i++) begin
            dn += int'(done64) + int'(busy64);
            @(posedge clk); #1;
        end
        chk("no_done_after_abort", dn, 32'd0);

        check_dump(1'b1, 64, 1'b0, 32'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
